// File: rtl/ram_burst_reader.sv
// Read-side burst master for the dual-port block RAM: issues sequential word
// reads, absorbs the 1-cycle RAM latency and streams words out over valid/ready.
module ram_burst_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_dout,
  output logic                  m_valid,
  output logic [31:0]           m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  iss_q, iss_d;   // a read address is on ram_addr this cycle
  logic                  cap_q;          // ram_dout carries a requested word this cycle
  logic [LEN_WIDTH-1:0]  rd_left_q, rd_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic [31:0]           fifo_q [4];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            cnt_q, cnt_d;
  logic                  push, pop, credit_ok;

  assign push = cap_q;
  assign pop  = m_valid & m_ready;
  assign cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  // The next cycle's occupancy plus the word still in flight must leave room
  // for the read we are about to launch.
  assign credit_ok = ({1'b0, cnt_d} + {3'b000, iss_q}) <= 4'd3;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_d      = 1'b0;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    if (pop) begin
      out_left_d = out_left_q - LEN_WIDTH'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          out_left_d = length;
          if (length == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d   = S_READ;
            iss_d     = 1'b1;
            addr_d    = start_addr;
            rd_left_d = length - LEN_WIDTH'(1);
          end
        end
      end
      S_READ: begin
        if (rd_left_q == '0) begin
          state_d = S_DRAIN;
        end else if (credit_ok) begin
          iss_d     = 1'b1;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          rd_left_d = rd_left_q - LEN_WIDTH'(1);
          if (rd_left_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((pop && m_last) || (out_left_q == '0)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      iss_q      <= 1'b0;
      cap_q      <= 1'b0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      // NOTE: the 4-entry buffer is small and m_data must read 0 out of
      // reset, so its storage is cleared here rather than left unreset.
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_q      <= iss_d;
      cap_q      <= iss_q;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      cnt_q      <= cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
    end
  end

  assign ram_addr = addr_q;
  assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done     = (state_q == S_FIN);
  assign m_valid  = (cnt_q != 3'd0);
  assign m_data   = fifo_q[rd_ptr_q];
  assign m_last   = m_valid && (out_left_q == LEN_WIDTH'(1));

endmodule
